// File: rtl/dmux_nway_reg_pkg.sv
// Shared constants and helpers for the n-way registered demux (package hack_pkg).
package hack_pkg;

   localparam int HACK_WORD_W = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/dmux_nway_reg_slot.sv
// One-entry output slot: holds a single word, refilled on the same edge it drains.
module dmux_slot
   import hack_pkg::*;
#(
   parameter int WIDTH = HACK_WORD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fill,
   input  logic             drain,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   logic             vld_q, vld_d;
   logic [WIDTH-1:0] data_q, data_d;

   // A fill always wins over a drain so back-to-back words stream at full rate.
   assign vld_d  = fill | (vld_q & ~drain);
   assign data_d = fill ? d : data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign q     = data_q;
   assign valid = vld_q;

endmodule

// File: rtl/dmux_nway_reg.sv
// Registered 1-to-NCH demux with per-channel valid/ready and a sticky bad-select flag.
// Optional broadcast input enabled by defining DMUX_BROADCAST_EN.
module dmux_nway_reg
   import hack_pkg::*;
#(
   parameter  int WIDTH = HACK_WORD_W,
   parameter  int NCH   = 4,
   localparam int SEL_W = clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [SEL_W-1:0]     in_sel,
`ifdef DMUX_BROADCAST_EN
   input  logic                 in_bcast,
`endif
   output logic [NCH-1:0]       out_valid,
   input  logic [NCH-1:0]       out_ready,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic                 err_sel
);

   logic [NCH-1:0] slot_vld, hit, free, fill, drain;
   logic           sel_ok, bcast, err_q, err_d;

`ifdef DMUX_BROADCAST_EN
   assign bcast = in_bcast;
`else
   assign bcast = 1'b0;
`endif

   assign sel_ok = ({1'b0, in_sel} < (SEL_W+1)'(NCH));

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign hit[k]   = (in_sel == SEL_W'(k));
      assign free[k]  = ~slot_vld[k] | out_ready[k];
      assign drain[k] = slot_vld[k] & out_ready[k];
      assign fill[k]  = in_valid & in_ready & (bcast | hit[k]);

      dmux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .fill  (fill[k]),
         .drain (drain[k]),
         .d     (in_data),
         .q     (out_data[k*WIDTH +: WIDTH]),
         .valid (slot_vld[k])
      );
   end

   // An out-of-range select matches no channel, so it is accepted and dropped.
   assign in_ready = bcast ? (&free) : (~sel_ok | (|(hit & free)));
   assign err_d    = err_q | (in_valid & ~sel_ok & ~bcast);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign out_valid = slot_vld;
   assign err_sel   = err_q;

endmodule

// File: tb/tb_dmux_nway_reg.sv
// Bench for dmux_nway_reg: directed table, corner sequences, random run vs slot model.
module tb_dmux_nway_reg;

   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_bcast = 1'b0;
   logic [15:0] in_data = '0;
   logic [1:0]  in_sel = '0;
   logic [3:0]  ordy = '0;
   logic        rdy4, rdy3, err4, err3;
   logic [3:0]  ov4;
   logic [2:0]  ov3;
   logic [63:0] od4;
   logic [47:0] od3;

   always #5 clk = ~clk;

   dmux_nway_reg #(.WIDTH(16), .NCH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
      .in_data(in_data), .in_sel(in_sel),
`ifdef DMUX_BROADCAST_EN
      .in_bcast(in_bcast),
`endif
      .out_valid(ov4), .out_ready(ordy), .out_data(od4), .err_sel(err4));

   dmux_nway_reg #(.WIDTH(16), .NCH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
      .in_data(in_data), .in_sel(in_sel),
`ifdef DMUX_BROADCAST_EN
      .in_bcast(in_bcast),
`endif
      .out_valid(ov3), .out_ready(ordy[2:0]), .out_data(od3), .err_sel(err3));

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference model: index 0 is the 4-channel DUT, index 1 the 3-channel DUT.
   bit          mf[2][4];
   logic [15:0] mw[2][4];
   bit          me[2];

   function automatic int nch(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   function automatic bit m_ready(input int d);
      bit r;
      r = 1'b1;
      if (in_bcast) begin
         for (int k = 0; k < nch(d); k++) if (mf[d][k] && !ordy[k]) r = 1'b0;
      end else if (int'(in_sel) < nch(d)) begin
         r = !mf[d][in_sel] || ordy[in_sel];
      end
      return r;
   endfunction

   task automatic m_reset();
      for (int d = 0; d < 2; d++) begin
         me[d] = 1'b0;
         for (int k = 0; k < 4; k++) begin mf[d][k] = 1'b0; mw[d][k] = '0; end
      end
   endtask

   task automatic m_step();
      for (int d = 0; d < 2; d++) begin
         bit r;
         r = m_ready(d);
         for (int k = 0; k < nch(d); k++) begin
            if (mf[d][k] && ordy[k]) mf[d][k] = 1'b0;
            if (in_valid && r && (in_bcast || int'(in_sel) == k)) begin
               mf[d][k] = 1'b1;
               mw[d][k] = in_data;
            end
         end
         if (in_valid && !in_bcast && int'(in_sel) >= nch(d)) me[d] = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_rdy4"}, rdy4, m_ready(0));
      chk({tag, "_rdy3"}, rdy3, m_ready(1));
      chk({tag, "_err4"}, err4, me[0]);
      chk({tag, "_err3"}, err3, me[1]);
      for (int k = 0; k < 4; k++) begin
         chk({tag, "_ov4"}, ov4[k], mf[0][k]);
         if (mf[0][k]) chk({tag, "_od4"}, od4[k*16 +: 16], mw[0][k]);
      end
      for (int k = 0; k < 3; k++) begin
         chk({tag, "_ov3"}, ov3[k], mf[1][k]);
         if (mf[1][k]) chk({tag, "_od3"}, od3[k*16 +: 16], mw[1][k]);
      end
   endtask

   // Called with inputs already driven just after a rising edge.
   task automatic cyc(input string tag);
      #4;
      check_all(tag);
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [1:0] s, input logic [15:0] d, input logic [3:0] r);
      in_valid = v; in_sel = s; in_data = d; ordy = r;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_reset();
      #12;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          v;
      logic [1:0]  s;
      logic [15:0] d;
      logic [3:0]  r;
      bit          er;
      logic [3:0]  eov;
      int          ch;
      bit          cd;
      logic [15:0] ed;
   } vec_t;

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{1'b1, 2'd0, 16'hA001, 4'hF, 1'b1, 4'b0000, 0, 1'b0, 16'h0};
      tbl[1]  = '{1'b1, 2'd1, 16'hA002, 4'hF, 1'b1, 4'b0001, 0, 1'b1, 16'hA001};
      tbl[2]  = '{1'b1, 2'd2, 16'hA003, 4'hF, 1'b1, 4'b0010, 1, 1'b1, 16'hA002};
      tbl[3]  = '{1'b1, 2'd3, 16'hA004, 4'hF, 1'b1, 4'b0100, 2, 1'b1, 16'hA003};
      tbl[4]  = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b1000, 3, 1'b1, 16'hA004};
      tbl[5]  = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0000, 0, 1'b0, 16'h0};
      tbl[6]  = '{1'b1, 2'd2, 16'hB001, 4'b1011, 1'b1, 4'b0000, 0, 1'b0, 16'h0};
      tbl[7]  = '{1'b1, 2'd2, 16'hB002, 4'b1011, 1'b0, 4'b0100, 2, 1'b1, 16'hB001};
      tbl[8]  = '{1'b1, 2'd1, 16'hB003, 4'b1011, 1'b1, 4'b0100, 2, 1'b1, 16'hB001};
      tbl[9]  = '{1'b1, 2'd2, 16'hB002, 4'hF, 1'b1, 4'b0110, 1, 1'b1, 16'hB003};
      tbl[10] = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0100, 2, 1'b1, 16'hB002};
      tbl[11] = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0000, 0, 1'b0, 16'h0};
      tbl[12] = '{1'b1, 2'd0, 16'hC001, 4'hF, 1'b1, 4'b0000, 0, 1'b0, 16'h0};
      tbl[13] = '{1'b1, 2'd0, 16'hC002, 4'hF, 1'b1, 4'b0001, 0, 1'b1, 16'hC001};
      tbl[14] = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0001, 0, 1'b1, 16'hC002};
      tbl[15] = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0000, 0, 1'b0, 16'h0};

      // Reset state, sampled while reset is held.
      m_reset();
      #7;
      chk("rst_ov4", ov4, 4'h0);
      chk("rst_od4", od4, 64'h0);
      chk("rst_err4", err4, 1'b0);
      chk("rst_rdy4", rdy4, 1'b1);
      chk("rst_ov3", ov3, 3'h0);
      chk("rst_err3", err3, 1'b0);
      do_reset();

      // Routing, backpressure, drain+fill on the 4-channel instance.
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r);
         #4;
         chk($sformatf("tbl%0d_rdy", i), rdy4, tbl[i].er);
         chk($sformatf("tbl%0d_ov", i), ov4, tbl[i].eov);
         if (tbl[i].cd) chk($sformatf("tbl%0d_data", i), od4[tbl[i].ch*16 +: 16], tbl[i].ed);
         m_step();
         @(posedge clk);
         #1;
      end

      // Out-of-range select on the 3-channel instance.
      do_reset();
      drive(1'b1, 2'd3, 16'hDEAD, 4'hF);
      #4;
      chk("oor_rdy3", rdy3, 1'b1);
      m_step();
      @(posedge clk);
      #1;
      drive(1'b0, 2'd0, 16'h0, 4'hF);
      #4;
      chk("oor_ov3", ov3, 3'h0);
      chk("oor_err3", err3, 1'b1);
      chk("oor_err4", err4, 1'b0);
      m_step();
      @(posedge clk);
      #1;
      drive(1'b1, 2'd2, 16'h5A5A, 4'hF);
      cyc("oor_in");
      drive(1'b0, 2'd0, 16'h0, 4'hF);
      cyc("oor_post");
      chk("oor_err3_sticky", err3, 1'b1);

      // Fill every slot, then reset asynchronously between edges.
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 2'(k), 16'hE000 + 16'(k), 4'h0);
         cyc("fill");
      end
      drive(1'b0, 2'd0, 16'h0, 4'h0);
      #2;
      chk("pre_rst_ov4", ov4, 4'hF);
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("arst_ov4", ov4, 4'h0);
      chk("arst_od4", od4, 64'h0);
      chk("arst_err3", err3, 1'b0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b0, 2'd0, 16'h0, 4'hF);
      for (int i = 0; i < 3; i++) begin
         cyc("post_rst");
         chk("post_rst_ov4", ov4, 4'h0);
      end

`ifdef DMUX_BROADCAST_EN
      // Broadcast with channel 1 stalled.
      do_reset();
      drive(1'b1, 2'd1, 16'h1111, 4'b1101);
      cyc("bc_pre");
      in_bcast = 1'b1;
      drive(1'b1, 2'd3, 16'h7FFF, 4'b1101);
      for (int i = 0; i < 2; i++) begin
         #4;
         chk("bc_stall_rdy", rdy4, 1'b0);
         m_step();
         @(posedge clk);
         #1;
      end
      ordy = 4'hF;
      #4;
      chk("bc_go_rdy", rdy4, 1'b1);
      m_step();
      @(posedge clk);
      #1;
      in_bcast = 1'b0;
      drive(1'b0, 2'd0, 16'h0, 4'h0);
      #4;
      chk("bc_ov", ov4, 4'hF);
      chk("bc_data", od4, 64'h7FFF7FFF7FFF7FFF);
      chk("bc_err", err4, 1'b0);
      m_step();
      @(posedge clk);
      #1;
`endif

      // Random traffic against the model, both instances in lockstep.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
`ifdef DMUX_BROADCAST_EN
         in_bcast = ($urandom_range(0, 7) == 0);
`endif
         cyc("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
